// File: rtl/mau_pkg.sv
// ============================================================================
// Module : mau_pkg
// Brief  : Shared op encodings, exception codes, FSM states and lane helpers
//          for the MEM-stage load/store access unit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mau_pkg;

    typedef enum logic [2:0] {
        LSU_LW  = 3'd0,
        LSU_LH  = 3'd1,
        LSU_LHU = 3'd2,
        LSU_LB  = 3'd3,
        LSU_LBU = 3'd4,
        LSU_SW  = 3'd5,
        LSU_SH  = 3'd6,
        LSU_SB  = 3'd7
    } lsu_op_e;

    localparam logic [1:0] EXC_NONE = 2'd0;
    localparam logic [1:0] EXC_ADEL = 2'd1;
    localparam logic [1:0] EXC_ADES = 2'd2;
    localparam logic [1:0] EXC_BUS  = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } mau_state_e;

    function automatic logic is_store(input lsu_op_e op);
        return (op == LSU_SW) || (op == LSU_SH) || (op == LSU_SB);
    endfunction

    function automatic logic is_misaligned(input lsu_op_e op, input logic [1:0] lane);
        case (op)
            LSU_LW, LSU_SW:          return lane != 2'b00;
            LSU_LH, LSU_LHU, LSU_SH: return lane[0];
            default:                 return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input lsu_op_e op, input logic [1:0] lane);
        case (op)
            LSU_LW, LSU_SW:          return 4'b1111;
            LSU_LH, LSU_LHU, LSU_SH: return 4'b0011 << lane;
            default:                 return 4'b0001 << lane;
        endcase
    endfunction

    // Replicate narrow store data so every lane carries it; be picks the lane.
    function automatic logic [31:0] store_data(input lsu_op_e op, input logic [31:0] wdata);
        case (op)
            LSU_SW:  return wdata;
            LSU_SH:  return {2{wdata[15:0]}};
            LSU_SB:  return {4{wdata[7:0]}};
            default: return 32'h0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/load_ext_unit.sv
// ============================================================================
// Module : load_ext_unit
// Brief  : Selects the addressed half/byte of a read word and sign- or
//          zero-extends it according to the load opcode.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module load_ext_unit
    import mau_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  lsu_op_e     op_i,
    output logic [31:0] data_o
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    always_comb begin
        w_half = word_i[{lane_i[1], 4'b0000} +: 16];
        w_byte = word_i[{lane_i, 3'b000} +: 8];
        case (op_i)
            LSU_LH:  data_o = {{16{w_half[15]}}, w_half};
            LSU_LHU: data_o = {16'h0000, w_half};
            LSU_LB:  data_o = {{24{w_byte[7]}}, w_byte};
            LSU_LBU: data_o = {24'h000000, w_byte};
            default: data_o = word_i;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module : mem_access_unit
// Brief  : MEM-stage load/store unit: one request at a time over a req/ack
//          data-memory handshake with alignment checks and bus timeout.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_access_unit
    import mau_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [2:0]        req_op_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_rdata_o,
    output logic [1:0]        rsp_exc_o,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_be_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [31:0]       mem_rdata_i
);

    mau_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    lsu_op_e           op_q, op_d;
    logic [1:0]        lane_q, lane_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic [1:0]        rsp_exc_q, rsp_exc_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    lsu_op_e           w_req_op;
    logic [1:0]        w_req_lane;
    logic [31:0]       w_ext_data;

    assign w_req_op   = lsu_op_e'(req_op_i);
    assign w_req_lane = req_addr_i[1:0];

    load_ext_unit u_load_ext (
        .word_i (mem_rdata_i),
        .lane_i (lane_q),
        .op_i   (op_q),
        .data_o (w_ext_data)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        lane_d      = lane_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_exc_d   = rsp_exc_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            ACCESS: begin
                // Ack has priority over a timeout landing in the same cycle.
                if (mem_ack_i) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_exc_d   = EXC_NONE;
                    rsp_rdata_d = is_store(op_q) ? 32'h0 : w_ext_data;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_exc_d   = EXC_BUS;
                    rsp_rdata_d = 32'h0;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                // RESP also samples req_valid so back-to-back issue has no idle gap.
                state_d = IDLE;
                if (req_valid_i) begin
                    if (is_misaligned(w_req_op, w_req_lane)) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_exc_d   = is_store(w_req_op) ? EXC_ADES : EXC_ADEL;
                        rsp_rdata_d = 32'h0;
                    end else begin
                        state_d     = ACCESS;
                        cnt_d       = '0;
                        op_d        = w_req_op;
                        lane_d      = w_req_lane;
                        mem_req_d   = 1'b1;
                        mem_we_d    = is_store(w_req_op);
                        mem_addr_d  = {req_addr_i[ADDR_W-1:2], 2'b00};
                        mem_be_d    = byte_enables(w_req_op, w_req_lane);
                        mem_wdata_d = store_data(w_req_op, req_wdata_i);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= LSU_LW;
            lane_q      <= 2'b00;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_exc_q   <= EXC_NONE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            lane_q      <= lane_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_exc_q   <= rsp_exc_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign stall_o     = (state_q != IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_exc_o   = rsp_exc_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_be_o    = mem_be_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module : tb_mem_access_unit
// Brief  : Directed scoreboard bench for mem_access_unit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_unit;
    import mau_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [2:0]  req_op_i = 3'd0;
    logic [31:0] req_addr_i = 32'h0;
    logic [31:0] req_wdata_i = 32'h0;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic [1:0]  rsp_exc_o;
    logic        stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'hDEAD_BEEF;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  exc;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    mem_access_unit #(.ADDR_W(32), .TIMEOUT(16), .CNT_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_op_i    (req_op_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_exc_o   (rsp_exc_o),
        .stall_o     (stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_be_o    (mem_be_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every response pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rsp_valid_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rdata %h exc %0d expected no response",
                         rsp_rdata_o, rsp_exc_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata_o, mon_e.rdata);
                check("rsp_exc", {30'b0, rsp_exc_o}, {30'b0, mon_e.exc});
            end
        end
    end

    task automatic expect_rsp(input logic [31:0] rdata, input logic [1:0] exc);
        rsp_t r;
        r.rdata = rdata;
        r.exc   = exc;
        exp_q.push_back(r);
    endtask

    task automatic issue(input lsu_op_e op, input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        req_valid_i = 1'b1;
        req_op_i    = op;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
    endtask

    task automatic access(input lsu_op_e op, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int k, input logic [3:0] ebe,
                          input logic [31:0] eaddr, input logic [31:0] ewdata, input logic ewe,
                          input logic [31:0] erdata, input bit drop_chk);
        expect_rsp(erdata, EXC_NONE);
        issue(op, addr, wdata);
        @(negedge clk);
        check("mem_req_on_accept", {31'b0, mem_req_o}, 32'd1);
        check("mem_we", {31'b0, mem_we_o}, {31'b0, ewe});
        check("mem_addr", mem_addr_o, eaddr);
        check("mem_be", {28'b0, mem_be_o}, {28'b0, ebe});
        if (ewe) check("mem_wdata", mem_wdata_o, ewdata);
        check("stall_busy", {31'b0, stall_o}, 32'd1);
        check("req_ready_busy", {31'b0, req_ready_o}, 32'd0);
        repeat (k - 1) @(negedge clk);
        check("mem_req_held", {31'b0, mem_req_o}, 32'd1);
        check("mem_addr_held", mem_addr_o, eaddr);
        mem_ack_i   = 1'b1;
        mem_rdata_i = rdata;
        @(posedge clk);
        #1;
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'hDEAD_BEEF;
        if (drop_chk) begin
            @(negedge clk);
            check("mem_req_dropped", {31'b0, mem_req_o}, 32'd0);
            check("rsp_valid_after_ack", {31'b0, rsp_valid_o}, 32'd1);
        end
    endtask

    task automatic misaligned(input lsu_op_e op, input logic [31:0] addr, input logic [1:0] exc);
        expect_rsp(32'h0, exc);
        issue(op, addr, 32'h0);
        @(negedge clk);
        check("misaligned_no_req", {31'b0, mem_req_o}, 32'd0);
        check("misaligned_rsp_valid", {31'b0, rsp_valid_o}, 32'd1);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata_o, 32'h0);
        check("rst_rsp_exc", {30'b0, rsp_exc_o}, 32'd0);
        check("rst_mem_req", {31'b0, mem_req_o}, 32'd0);
        check("rst_mem_we", {31'b0, mem_we_o}, 32'd0);
        check("rst_mem_addr", mem_addr_o, 32'h0);
        check("rst_mem_be", {28'b0, mem_be_o}, 32'd0);
        check("rst_mem_wdata", mem_wdata_o, 32'h0);
        check("rst_stall", {31'b0, stall_o}, 32'd0);
        check("rst_req_ready", {31'b0, req_ready_o}, 32'd1);

        // LB sign-extends byte lane 3; response must be a single-cycle pulse.
        access(LSU_LB, 32'h1003, 32'h0, 32'h80FF_1234, 2, 4'b1000, 32'h1000, 32'h0, 1'b0,
               32'hFFFF_FF80, 1'b1);
        @(negedge clk);
        check("rsp_single_cycle", {31'b0, rsp_valid_o}, 32'd0);
        check("req_ready_idle", {31'b0, req_ready_o}, 32'd1);

        access(LSU_LHU, 32'h2002, 32'h0, 32'h9ABC_0000, 1, 4'b1100, 32'h2000, 32'h0, 1'b0,
               32'h0000_9ABC, 1'b1);
        access(LSU_LH, 32'h2002, 32'h0, 32'h9ABC_0000, 1, 4'b1100, 32'h2000, 32'h0, 1'b0,
               32'hFFFF_9ABC, 1'b1);
        access(LSU_LBU, 32'h1001, 32'h0, 32'h80FF_1234, 3, 4'b0010, 32'h1000, 32'h0, 1'b0,
               32'h0000_0012, 1'b1);
        access(LSU_SB, 32'h0001, 32'h1234_56A5, 32'h0, 2, 4'b0010, 32'h0, 32'hA5A5_A5A5, 1'b1,
               32'h0, 1'b1);
        access(LSU_SH, 32'h0002, 32'h0000_BEEF, 32'h0, 1, 4'b1100, 32'h0, 32'hBEEF_BEEF, 1'b1,
               32'h0, 1'b1);

        misaligned(LSU_LW, 32'h0006, EXC_ADEL);
        misaligned(LSU_SH, 32'h0003, EXC_ADES);

        // No ack at all: request held exactly TIMEOUT cycles, then bus error.
        expect_rsp(32'h0, EXC_BUS);
        issue(LSU_LW, 32'h0100, 32'h0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_req_o) n++;
            else break;
        end
        check("timeout_req_cycles", n, 32'd16);

        // Ack on the timeout cycle wins.
        access(LSU_LW, 32'h0040, 32'h0, 32'hCAFE_F00D, 16, 4'b1111, 32'h0040, 32'h0, 1'b0,
               32'hCAFE_F00D, 1'b1);

        // Reset mid-access, then a stray ack: nothing should come back.
        issue(LSU_LW, 32'h0010, 32'h0);
        repeat (3) @(negedge clk);
        check("pre_reset_req", {31'b0, mem_req_o}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midrst_mem_req", {31'b0, mem_req_o}, 32'd0);
        check("midrst_req_ready", {31'b0, req_ready_o}, 32'd1);
        check("midrst_stall", {31'b0, stall_o}, 32'd0);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h1111_2222;
        @(posedge clk);
        #1;
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'hDEAD_BEEF;
        @(negedge clk);
        check("stray_ack_no_rsp", {31'b0, rsp_valid_o}, 32'd0);
        check("stray_ack_idle", {31'b0, req_ready_o}, 32'd1);

        // Back-to-back: the LW is presented while the SW response is showing.
        access(LSU_SW, 32'h0080, 32'h1122_3344, 32'h0, 1, 4'b1111, 32'h0080, 32'h1122_3344,
               1'b1, 32'h0, 1'b0);
        access(LSU_LW, 32'h0084, 32'h0, 32'h5566_7788, 3, 4'b1111, 32'h0084, 32'h0, 1'b0,
               32'h5566_7788, 1'b1);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1);
    end

endmodule

`default_nettype wire
